// File: rtl/recovery_pkg.sv
// rtl/recovery_pkg.sv - shared state encoding for the checkpoint/restore regfile
// Purpose: restore sequencer state type used by recovery_restore_fsm.
// Contents: rstr_state_t (ST_IDLE, ST_RESTORE, ST_DONE).
package recovery_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTORE = 2'd1,
    ST_DONE    = 2'd2
  } rstr_state_t;

endpackage

// File: rtl/recovery_restore_fsm.sv
// rtl/recovery_restore_fsm.sv - rollback sequencer: state, index counter, stream handshake
// Purpose: walks the checkpoint bank index by index and streams each entry out.
// Ports:
//   clk, rst_in      clock, async active-low reset
//   start            begin a rollback (only honoured in ST_IDLE)
//   rs_ready         downstream accepts the current beat
//   rs_valid         beat presented (registered)
//   rs_addr          index of the presented entry (registered)
//   beat             rs_valid & rs_ready, the cycle an entry is copied back
//   busy             rollback in progress, RESTORE or DONE (registered)
//   done             one-cycle completion pulse (registered)
module recovery_restore_fsm
  import recovery_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int ZERO_R0 = 1,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              start,
  input  logic              rs_ready,
  output logic              rs_valid,
  output logic [ADDR_W-1:0] rs_addr,
  output logic              beat,
  output logic              busy,
  output logic              done
);

  // Entry 0 is hard-wired to zero when ZERO_R0 is set, so there is nothing to replay.
  localparam logic [ADDR_W-1:0] FIRST_IDX = (ZERO_R0 != 0) ? ADDR_W'(1) : ADDR_W'(0);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  rstr_state_t state;

  assign beat = rs_valid & rs_ready;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state    <= ST_IDLE;
      rs_addr  <= '0;
      rs_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RESTORE;
            rs_addr  <= FIRST_IDX;
            rs_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_RESTORE: begin
          // Address only advances on an accepted beat, so a stall holds it.
          if (rs_ready) begin
            if (rs_addr == LAST_IDX) begin
              state    <= ST_DONE;
              rs_valid <= 1'b0;
              done     <= 1'b1;
            end else begin
              rs_addr <= rs_addr + ADDR_W'(1);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          rs_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/recovery_ckpt_regfile.sv
// rtl/recovery_ckpt_regfile.sv - register file with single-cycle checkpoint and streamed rollback
// Purpose: live bank for normal read/write, ckpt bank snapshotted on commit and
//          replayed into live (and out on the rs_* stream) on restore.
// Ports:
//   clk, rst_in          clock, async active-low reset (clears both banks)
//   we, wa, wd           live write port (IDLE only)
//   ra, rd               combinational live read
//   commit, restore      snapshot / rollback request pulses
//   rs_valid, rs_ready, rs_addr, rs_data   restore stream
//   busy, done, wr_drop  status: rollback active, completion pulse, rejected write pulse
module recovery_ckpt_regfile
  import recovery_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int ZERO_R0 = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd,
  input  logic              commit,
  input  logic              restore,
  output logic              rs_valid,
  input  logic              rs_ready,
  output logic [ADDR_W-1:0] rs_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic              busy,
  output logic              done,
  output logic              wr_drop
);

  logic [DATA_W-1:0] live [DEPTH];
  logic [DATA_W-1:0] ckpt [DEPTH];

  logic start;
  logic beat;
  logic wr_ok;
  logic snap;
  logic r0_hit_w;

  // A restore request outranks both a same-cycle write and a same-cycle commit.
  assign start    = restore & ~busy;
  assign r0_hit_w = (ZERO_R0 != 0) && (wa == '0);
  assign wr_ok    = we & ~busy & ~restore & ~r0_hit_w;
  assign snap     = commit & ~busy & ~restore;

  recovery_restore_fsm #(
    .DEPTH   (DEPTH),
    .ZERO_R0 (ZERO_R0),
    .ADDR_W  (ADDR_W)
  ) u_fsm (
    .clk      (clk),
    .rst_in   (rst_in),
    .start    (start),
    .rs_ready (rs_ready),
    .rs_valid (rs_valid),
    .rs_addr  (rs_addr),
    .beat     (beat),
    .busy     (busy),
    .done     (done)
  );

  // wr_ok and beat are mutually exclusive (beat implies busy).
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) live[i] <= '0;
    end else if (wr_ok) begin
      live[wa] <= wd;
    end else if (beat) begin
      live[rs_addr] <= ckpt[rs_addr];
    end
  end

  // Snapshot forwards a same-cycle write so the checkpoint matches post-write state.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) ckpt[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < DEPTH; i++)
        ckpt[i] <= (wr_ok && (wa == ADDR_W'(i))) ? wd : live[i];
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) wr_drop <= 1'b0;
    else         wr_drop <= we & (busy | restore);
  end

  always_comb begin
    rd = '0;
    if (rst_in && !((ZERO_R0 != 0) && (ra == '0))) rd = live[ra];
  end

  // ckpt is frozen while busy, so this stays stable across stalls.
  assign rs_data = ckpt[rs_addr];

endmodule

// File: doc/recovery_ckpt_regfile.md
RECOVERY_CKPT_REGFILE -- requirements
Module: recovery_ckpt_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter DEPTH, default 32, number of entries (power of two, >=2).
REQ-003 SHALL have parameter ZERO_R0, default 1, entry 0 reads 0 and ignores writes when 1.
REQ-004 SHALL derive localparam ADDR_W = clog2(DEPTH).
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port rst_in  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have ports we / wa / wd  in  1 / ADDR_W / DATA_W  live write enable, address, data.
REQ-008 SHALL have ports ra  in  ADDR_W and rd  out  DATA_W  combinational live read.
REQ-009 SHALL have port commit  in  1  pulse: snapshot live bank into checkpoint bank.
REQ-010 SHALL have port restore  in  1  pulse: start rollback from checkpoint bank.
REQ-011 SHALL have ports rs_valid out 1, rs_ready in 1, rs_addr out ADDR_W, rs_data out DATA_W  restore stream to pipeline regfile.
REQ-012 SHALL have ports busy out 1 (restore in progress), done out 1 (one-cycle pulse), wr_drop out 1 (one-cycle pulse, write rejected).

Function
REQ-013 SHALL hold two banks, live and ckpt, each DEPTH x DATA_W.
REQ-014 SHALL write live[wa] <= wd on clk when we=1 and state IDLE; rd = live[ra], 0 if ra=0 and ZERO_R0=1, 0 while rst_in=0.
REQ-015 SHALL, on commit=1 in IDLE, copy all live entries to ckpt in one cycle, including any same-cycle write (ckpt[wa] gets wd).
REQ-016 SHALL implement FSM IDLE -> RESTORE -> DONE -> IDLE.
REQ-017 SHALL enter RESTORE from IDLE on restore=1, index counter = 0; restore has priority over same-cycle commit (commit dropped) and same-cycle write (write dropped, wr_drop=1).
REQ-018 SHALL, in RESTORE, drive rs_valid=1, rs_addr=index, rs_data=ckpt[index]; on rs_valid&rs_ready copy ckpt[index] into live[index] and increment index.
REQ-019 SHALL hold rs_addr/rs_data stable while rs_valid=1 and rs_ready=0.
REQ-020 SHALL skip index 0 when ZERO_R0=1 (stream starts at 1; DEPTH-1 beats), else DEPTH beats.
REQ-021 SHALL move to DONE after the beat at index DEPTH-1 (no wrap); DONE asserts done=1 for one cycle then returns to IDLE.
REQ-022 SHALL assert busy=1 in RESTORE and DONE; we during busy is ignored and pulses wr_drop=1 next cycle-registered.
REQ-023 SHALL ignore commit and restore while busy.
REQ-024 SHALL leave rd reading live bank during restore (partially restored values visible).

Reset
REQ-025 SHALL, on rst_in=0, immediately clear both banks, index, FSM to IDLE; rs_valid, busy, done, wr_drop = 0; rd = 0.
REQ-026 SHALL abort an in-flight restore on reset with no done pulse.

Structure
REQ-027 SHALL place FSM state encoding (IDLE, RESTORE, DONE) in shared package recovery_pkg.
REQ-028 SHALL keep the bank arrays inline; one sub-module, recovery_restore_fsm (FSM + index counter + handshake), is natural.

Verification
REQ-029 SHALL test write live[5]=0xDEADBEEF, read ra=5 -> rd=0xDEADBEEF; write wa=0 -> rd(0)=0.
REQ-030 SHALL test commit same cycle as write wa=3 wd=0x11, then write wa=3 wd=0x22, restore -> beat rs_addr=3 carries 0x11, live[3]=0x11 after done.
REQ-031 SHALL test restore with rs_ready=1 constantly -> 31 beats addr 1..31, done one cycle after last beat, busy high for 32 cycles.
REQ-032 SHALL test rs_ready toggling 1/0 -> rs_addr/rs_data stable while stalled, no beat skipped or repeated.
REQ-033 SHALL test we=1 during RESTORE -> wr_drop=1, live unchanged; commit+restore same cycle -> ckpt unchanged.
REQ-034 SHALL test rst_in low at beat 10 of restore -> busy=0, rs_valid=0, rd=0, all entries 0, no done pulse.
